// File: rtl/simd_adder_arbiter_if.sv
// Request/adder/response bundle between the issue logic, the shared SIMD adder and its arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/adder side.
interface simd_adder_arbiter_if #(
  parameter int SIMD_WIDTH = 256,
  parameter int TAG_W      = 4
);
  logic [1:0]              rq_valid;
  logic [1:0]              rq_ready;
  logic [2*SIMD_WIDTH-1:0] rq_a;
  logic [2*SIMD_WIDTH-1:0] rq_b;
  logic [5:0]              rq_mode;
  logic [1:0]              rq_sub;
  logic [1:0]              rq_imm;
  logic [15:0]             rq_imm_reg;
  logic [2*TAG_W-1:0]      rq_tag;

  logic [SIMD_WIDTH-1:0]   add_a;
  logic [SIMD_WIDTH-1:0]   add_b;
  logic [2:0]              add_mode;
  logic                    add_sub;
  logic                    add_imm;
  logic [7:0]              add_imm_reg;
  logic [SIMD_WIDTH-1:0]   add_out;

  logic                    rs_valid;
  logic                    rs_ready;
  logic [SIMD_WIDTH-1:0]   rs_data;
  logic                    rs_port;
  logic [TAG_W-1:0]        rs_tag;
  logic                    rs_err;

  modport slave (
    input  rq_valid, rq_a, rq_b, rq_mode, rq_sub, rq_imm, rq_imm_reg, rq_tag,
    input  add_out, rs_ready,
    output rq_ready, add_a, add_b, add_mode, add_sub, add_imm, add_imm_reg,
    output rs_valid, rs_data, rs_port, rs_tag, rs_err
  );

  modport master (
    output rq_valid, rq_a, rq_b, rq_mode, rq_sub, rq_imm, rq_imm_reg, rq_tag,
    output add_out, rs_ready,
    input  rq_ready, add_a, add_b, add_mode, add_sub, add_imm, add_imm_reg,
    input  rs_valid, rs_data, rs_port, rs_tag, rs_err
  );
endinterface

// File: rtl/simd_adder_arbiter.sv
// Round-robin share of one combinational SIMD adder between two requesters (IDLE -> EXEC -> RESP).
// Define SIMD_ARB_PERF_CNT_EN to add the perf_ops0/perf_ops1/perf_stall counters.
module simd_adder_arbiter #(
  parameter int SIMD_WIDTH = 256,
  parameter int TAG_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  simd_adder_arbiter_if.slave    bus
`ifdef SIMD_ARB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_ops0,
  output logic [31:0]            perf_ops1,
  output logic [31:0]            perf_stall
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [SIMD_WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [2:0]            add_mode_q, add_mode_d;
  logic                  add_sub_q, add_sub_d, add_imm_q, add_imm_d;
  logic [7:0]            add_imm_reg_q, add_imm_reg_d;
  logic                  rs_valid_q, rs_valid_d, rs_err_q, rs_err_d;
  logic                  rs_port_q, rs_port_d;
  logic [TAG_W-1:0]      rs_tag_q, rs_tag_d;
  logic [SIMD_WIDTH-1:0] rs_data_q, rs_data_d;
  logic [1:0]            gnt;
  logic                  sel, hs;

  // Grant is only offered in IDLE; on contention the port not served last wins.
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE && !rst) begin
      case (bus.rq_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel = gnt[1];
  assign hs  = |gnt;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    add_a_d       = add_a_q;
    add_b_d       = add_b_q;
    add_mode_d    = add_mode_q;
    add_sub_d     = add_sub_q;
    add_imm_d     = add_imm_q;
    add_imm_reg_d = add_imm_reg_q;
    rs_valid_d    = rs_valid_q;
    rs_err_d      = rs_err_q;
    rs_port_d     = rs_port_q;
    rs_tag_d      = rs_tag_q;
    rs_data_d     = rs_data_q;
    case (state_q)
      IDLE: if (hs) begin
        add_a_d       = sel ? bus.rq_a[2*SIMD_WIDTH-1:SIMD_WIDTH] : bus.rq_a[SIMD_WIDTH-1:0];
        add_b_d       = sel ? bus.rq_b[2*SIMD_WIDTH-1:SIMD_WIDTH] : bus.rq_b[SIMD_WIDTH-1:0];
        add_mode_d    = sel ? bus.rq_mode[5:3] : bus.rq_mode[2:0];
        add_sub_d     = bus.rq_sub[sel];
        add_imm_d     = bus.rq_imm[sel];
        add_imm_reg_d = sel ? bus.rq_imm_reg[15:8] : bus.rq_imm_reg[7:0];
        rs_port_d     = sel;
        rs_tag_d      = sel ? bus.rq_tag[2*TAG_W-1:TAG_W] : bus.rq_tag[TAG_W-1:0];
        last_grant_d  = sel;
        state_d       = EXEC;
      end
      EXEC: begin
        // Modes 6/7 have no lane width: flag them and return zero data.
        rs_err_d   = add_mode_q > 3'd5;
        rs_data_d  = (add_mode_q > 3'd5) ? '0 : bus.add_out;
        rs_valid_d = 1'b1;
        state_d    = RESP;
      end
      RESP: if (bus.rs_ready) begin
        rs_valid_d = 1'b0;
        rs_err_d   = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_mode_q    <= '0;
      add_sub_q     <= 1'b0;
      add_imm_q     <= 1'b0;
      add_imm_reg_q <= '0;
      rs_valid_q    <= 1'b0;
      rs_err_q      <= 1'b0;
      rs_port_q     <= 1'b0;
      rs_tag_q      <= '0;
      rs_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      add_a_q       <= add_a_d;
      add_b_q       <= add_b_d;
      add_mode_q    <= add_mode_d;
      add_sub_q     <= add_sub_d;
      add_imm_q     <= add_imm_d;
      add_imm_reg_q <= add_imm_reg_d;
      rs_valid_q    <= rs_valid_d;
      rs_err_q      <= rs_err_d;
      rs_port_q     <= rs_port_d;
      rs_tag_q      <= rs_tag_d;
      rs_data_q     <= rs_data_d;
    end
  end

  assign bus.rq_ready    = gnt;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.add_mode    = add_mode_q;
  assign bus.add_sub     = add_sub_q;
  assign bus.add_imm     = add_imm_q;
  assign bus.add_imm_reg = add_imm_reg_q;
  assign bus.rs_valid    = rs_valid_q;
  assign bus.rs_err      = rs_err_q;
  assign bus.rs_port     = rs_port_q;
  assign bus.rs_tag      = rs_tag_q;
  assign bus.rs_data     = rs_data_q;

`ifdef SIMD_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops0  <= '0;
      perf_ops1  <= '0;
      perf_stall <= '0;
    end else begin
      if (hs && !sel) perf_ops0 <= perf_ops0 + 32'd1;
      if (hs && sel)  perf_ops1 <= perf_ops1 + 32'd1;
      if (state_q == RESP && !bus.rs_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_adder_arbiter.sv
// Directed bench for simd_adder_arbiter with a behavioural SIMD adder on add_out.
module tb_simd_adder_arbiter;
  localparam int W  = 256;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  simd_adder_arbiter_if #(.SIMD_WIDTH(W), .TAG_W(TW)) bus ();

`ifdef SIMD_ARB_PERF_CNT_EN
  logic [31:0] perf_ops0, perf_ops1, perf_stall;
  simd_adder_arbiter #(.SIMD_WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .perf_ops0(perf_ops0), .perf_ops1(perf_ops1), .perf_stall(perf_stall));
`else
  simd_adder_arbiter #(.SIMD_WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  // Lane-wise add/sub with optional sign-extended immediate; illegal modes give a^b so zeroing is visible.
  function automatic logic [W-1:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [2:0] m, input logic s, input logic im,
                                                input logic [7:0] ir);
    logic [W-1:0] r;
    logic c, bb;
    int lw, k;
    if (m > 3'd5) return a ^ b;
    lw = 8 << m;
    c  = 1'b0;
    r  = '0;
    for (int i = 0; i < W; i++) begin
      k = i % lw;
      if (k == 0) c = s;
      bb   = im ? ((k < 8) ? ir[k] : ir[7]) : b[i];
      bb   = bb ^ s;
      r[i] = a[i] ^ bb ^ c;
      c    = (a[i] & bb) | (a[i] & c) | (bb & c);
    end
    return r;
  endfunction

  always_comb bus.add_out = adder_model(bus.add_a, bus.add_b, bus.add_mode, bus.add_sub,
                                        bus.add_imm, bus.add_imm_reg);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rs_valid(input string tag);
    for (int i = 0; i < 8 && bus.rs_valid !== 1'b1; i++) step();
    chk(tag, W'(bus.rs_valid), W'(1));
  endtask

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 8 && bus.rq_ready === 2'b00; i++) step();
    chk(tag, W'(bus.rq_ready !== 2'b00), W'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    rst = 1'b1;
    bus.rq_valid = 2'b11; bus.rq_a = '0; bus.rq_b = '0; bus.rq_mode = '0;
    bus.rq_sub = '0; bus.rq_imm = '0; bus.rq_imm_reg = '0; bus.rq_tag = '0;
    bus.rs_ready = 1'b0;
    step(); step();
    // reset state
    chk("rst_rq_ready", W'(bus.rq_ready), W'(0));
    chk("rst_rs_valid", W'(bus.rs_valid), W'(0));
    chk("rst_rs_data", bus.rs_data, '0);
    chk("rst_rs_meta", W'({bus.rs_port, bus.rs_tag, bus.rs_err}), W'(0));
    chk("rst_add_a", bus.add_a, '0);
    chk("rst_add_ctl", W'({bus.add_mode, bus.add_sub, bus.add_imm, bus.add_imm_reg}), W'(0));
    bus.rq_valid = 2'b00;
    rst = 1'b0;
    step();

    // 1: port0 8b add 0xFF+0x01 -> 0x00, tag 3
    bus.rq_a[W-1:0] = {32{8'hFF}}; bus.rq_b[W-1:0] = {32{8'h01}};
    bus.rq_mode = 6'd0; bus.rq_tag = 8'h03; bus.rq_valid = 2'b01; bus.rs_ready = 1'b1;
    #1;
    chk("t1_grant", W'(bus.rq_ready), W'(2'b01));
    step();
    bus.rq_valid = 2'b00;
    chk("t1_exec_rs_valid", W'(bus.rs_valid), W'(0));
    chk("t1_add_a", bus.add_a, {32{8'hFF}});
    step();
    chk("t1_rs_valid", W'(bus.rs_valid), W'(1));
    chk("t1_rs_data", bus.rs_data, '0);
    chk("t1_rs_meta", W'({bus.rs_port, bus.rs_tag, bus.rs_err}), W'({1'b0, 4'd3, 1'b0}));
    step();
    chk("t1_rs_done", W'(bus.rs_valid), W'(0));

    // Reset so last_grant restarts at 1 and counters clear
    rst = 1'b1; step(); rst = 1'b0;

    // 2: both valid, grants alternate starting at port0
    bus.rq_a = {{16{16'h1000}}, {32{8'h01}}};
    bus.rq_b = {{16{16'h0234}}, {32{8'h02}}};
    bus.rq_mode = {3'd1, 3'd0}; bus.rq_tag = {4'hA, 4'h5};
    bus.rq_valid = 2'b11; bus.rs_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_grant("t2_grant_timeout");
      chk("t2_grant_order", W'(bus.rq_ready), (g % 2 == 0) ? W'(2'b01) : W'(2'b10));
      step();
      wait_rs_valid("t2_rs_timeout");
      chk("t2_rs_port", W'(bus.rs_port), W'(g % 2));
      chk("t2_rs_tag", W'(bus.rs_tag), (g % 2 == 0) ? W'(4'h5) : W'(4'hA));
      chk("t2_rs_data", bus.rs_data, (g % 2 == 0) ? {32{8'h03}} : {16{16'h1234}});
      step();
    end
    bus.rq_valid = 2'b00;

    // 3: port1 32b, imm 0x80, sub, A=0 -> 0x00000080 per lane
    bus.rq_a = '0; bus.rq_b = {64{8'h55}};
    bus.rq_mode = {3'd2, 3'd0}; bus.rq_sub = 2'b10; bus.rq_imm = 2'b10;
    bus.rq_imm_reg = 16'h8000; bus.rq_tag = {4'h6, 4'h0}; bus.rq_valid = 2'b10;
    wait_grant("t3_grant_timeout");
    chk("t3_grant", W'(bus.rq_ready), W'(2'b10));
    step();
    bus.rq_valid = 2'b00;
    chk("t3_add_ctl", W'({bus.add_mode, bus.add_sub, bus.add_imm, bus.add_imm_reg}),
        W'({3'd2, 1'b1, 1'b1, 8'h80}));
    wait_rs_valid("t3_rs_timeout");
    chk("t3_rs_data", bus.rs_data, {8{32'h0000_0080}});
    chk("t3_rs_meta", W'({bus.rs_port, bus.rs_tag}), W'({1'b1, 4'h6}));
    step();
    bus.rq_sub = '0; bus.rq_imm = '0; bus.rq_imm_reg = '0;

    // 4: 5 stalled RESP cycles, fields stable, no grant while both valid
    bus.rq_a[W-1:0] = {32{8'h10}}; bus.rq_b[W-1:0] = {32{8'h20}};
    bus.rq_mode = 6'd0; bus.rq_tag = {4'h0, 4'h7}; bus.rq_valid = 2'b01; bus.rs_ready = 1'b0;
    wait_grant("t4_grant_timeout");
    step();
    bus.rq_valid = 2'b11;
    wait_rs_valid("t4_rs_timeout");
    held = bus.rs_data;
    chk("t4_rs_data", held, {32{8'h30}});
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", W'(bus.rs_valid), W'(1));
      chk("t4_hold_data", bus.rs_data, {32{8'h30}});
      chk("t4_hold_meta", W'({bus.rs_port, bus.rs_tag, bus.rs_err}), W'({1'b0, 4'h7, 1'b0}));
      chk("t4_no_grant", W'(bus.rq_ready), W'(0));
      step();
    end
`ifdef SIMD_ARB_PERF_CNT_EN
    chk("t4_perf_stall", W'(perf_stall), W'(5));
    chk("t4_perf_ops0", W'(perf_ops0), W'(4));
    chk("t4_perf_ops1", W'(perf_ops1), W'(4));
`endif
    bus.rq_valid = 2'b00; bus.rs_ready = 1'b1;
    step();
    chk("t4_rs_done", W'(bus.rs_valid), W'(0));

    // 5: illegal mode 6 -> zero data, err set then cleared
    bus.rq_a[W-1:0] = {32{8'h0F}}; bus.rq_b[W-1:0] = {32{8'hF0}};
    bus.rq_mode = 6'd6; bus.rq_tag = {4'h0, 4'h9}; bus.rq_valid = 2'b01;
    wait_grant("t5_grant_timeout");
    step();
    bus.rq_valid = 2'b00;
    wait_rs_valid("t5_rs_timeout");
    chk("t5_rs_data", bus.rs_data, '0);
    chk("t5_rs_err", W'(bus.rs_err), W'(1));
    step();
    chk("t5_err_clr", W'({bus.rs_valid, bus.rs_err}), W'(0));

    // 6: reset in EXEC discards the op; next request completes
    bus.rq_a[2*W-1:W] = {32{8'h11}}; bus.rq_b[2*W-1:W] = {32{8'h22}};
    bus.rq_mode = 6'd0; bus.rq_tag = {4'h2, 4'h0}; bus.rq_valid = 2'b10;
    wait_grant("t6_grant_timeout");
    step();
    bus.rq_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("t6_rst_no_grant", W'(bus.rq_ready), W'(0));
    step();
    rst = 1'b0;
    chk("t6_rs_valid", W'(bus.rs_valid), W'(0));
    chk("t6_add_a", bus.add_a, '0);
    step();
    chk("t6_no_resp", W'(bus.rs_valid), W'(0));
    bus.rq_a[W-1:0] = {32{8'h07}}; bus.rq_b[W-1:0] = {32{8'h08}};
    bus.rq_tag = {4'h0, 4'hC}; bus.rq_valid = 2'b01;
    #1;
    chk("t6_idle_grant", W'(bus.rq_ready), W'(2'b01));
    step();
    bus.rq_valid = 2'b00;
    wait_rs_valid("t6_rs_timeout");
    chk("t6_rs_data", bus.rs_data, {32{8'h0F}});
    chk("t6_rs_meta", W'({bus.rs_port, bus.rs_tag, bus.rs_err}), W'({1'b0, 4'hC, 1'b0}));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
